// File: rtl/rect_fill_engine_if.sv
// Command and pixel-port bundle between the game controller, the rectangle
// engine and the VGA adapter write port.
interface rect_fill_engine_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    // Command side
    logic                start;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      width;
    logic [Y_W-1:0]      height;
    logic [COLOUR_W-1:0] colour_in;
    logic                mode;
    logic                busy;
    logic                done;

    // Adapter side
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (
        output start, x0, y0, width, height, colour_in, mode,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, width, height, colour_in, mode,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle raster engine: optional full-screen clear after reset, then clipped
// solid or outline rectangles, one registered pixel per clock.
module rect_fill_engine #(
    parameter int                  SCREEN_W       = 160,
    parameter int                  SCREEN_H       = 120,
    parameter int                  X_W            = 8,
    parameter int                  Y_W            = 7,
    parameter int                  COLOUR_W       = 3,
    parameter bit                  CLEAR_ON_RESET = 1'b1,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR   = 3'b111
) (
    input  logic                    clock,
    input  logic                    resetn,
    rect_fill_engine_if.slave       bus
);

    localparam logic [X_W:0]   SW    = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SH    = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_DRAW,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Command latched at accept: origin, last column/row and mode
    logic [X_W-1:0]      x0_q, x0_d, xl_q, xl_d;
    logic [Y_W-1:0]      y0_q, y0_d, yl_q, yl_d;
    logic                mode_q, mode_d;

    // Clipped extents, computed one bit wider so SCREEN - origin cannot wrap
    logic [X_W:0] x_room, ew, x_last;
    logic [Y_W:0] y_room, eh, y_last;

    assign x_room = ({1'b0, bus.x0} >= SW) ? '0 : SW - {1'b0, bus.x0};
    assign y_room = ({1'b0, bus.y0} >= SH) ? '0 : SH - {1'b0, bus.y0};
    assign ew     = ({1'b0, bus.width}  < x_room) ? {1'b0, bus.width}  : x_room;
    assign eh     = ({1'b0, bus.height} < y_room) ? {1'b0, bus.height} : y_room;
    assign x_last = {1'b0, bus.x0} + ew - 1'b1;
    assign y_last = {1'b0, bus.y0} + eh - 1'b1;

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        x0_d     = x0_q;
        y0_d     = y0_q;
        xl_d     = xl_q;
        yl_d     = yl_q;
        mode_d   = mode_q;

        unique case (state_q)
            S_CLEAR: begin
                busy_d   = 1'b1;
                plot_d   = 1'b1;
                colour_d = CLEAR_COLOUR;
                // plot low means (0,0) has not been presented yet
                if (!plot_q) begin
                    x_d = '0;
                    y_d = '0;
                end else if (x_q == X_MAX) begin
                    if (y_q == Y_MAX) begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        plot_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (bus.start) begin
                    x0_d     = bus.x0;
                    y0_d     = bus.y0;
                    xl_d     = x_last[X_W-1:0];
                    yl_d     = y_last[Y_W-1:0];
                    mode_d   = bus.mode;
                    colour_d = bus.colour_in;
                    if (ew == '0 || eh == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        // First pixel sits on the top row, so it is always a border pixel
                        state_d = S_DRAW;
                        busy_d  = 1'b1;
                        plot_d  = 1'b1;
                        x_d     = bus.x0;
                        y_d     = bus.y0;
                    end
                end
            end

            S_DRAW: begin
                busy_d = 1'b1;
                if (x_q == xl_q && y_q == yl_q) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    if (x_q == xl_q) begin
                        x_d = x0_q;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    // NOTE: blocking assignments in combinational logic, so x_d/y_d
                    // read back here already hold the next pixel position.
                    plot_d = !mode_q || x_d == x0_q || x_d == xl_q ||
                             y_d == y0_q || y_d == yl_q;
                end
            end

            S_FINISH: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // NOTE: command registers carry no reset; they are always loaded on accept
    // before any state reads them.
    always_ff @(posedge clock) begin
        x0_q   <= x0_d;
        y0_q   <= y0_d;
        xl_q   <= xl_d;
        yl_q   <= yl_d;
        mode_q <= mode_d;
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: reset clear, directed and random
// rectangles against a pixel-list model, busy/ignore and reset mid-draw.
module tb_rect_fill_engine;

    localparam int SW = 160;
    localparam int SH = 120;

    logic clock;
    logic resetn;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int y;
        bit plot;
    } pix_t;

    pix_t exp_q[$];

    rect_fill_engine_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    rect_fill_engine dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Observed vector: {plot, busy, done, x, y, colour}
    function automatic logic [20:0] cur();
        return {bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour};
    endfunction

    function automatic logic [20:0] pk(input bit p, input bit b, input bit d,
                                       input int xx, input int yy, input logic [2:0] c);
        return {p, b, d, 8'(xx), 7'(yy), c};
    endfunction

    function automatic logic [20:0] ctl();
        return {18'b0, bus.plot, bus.busy, bus.done};
    endfunction

    task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected pixel list: every scanned position of the clipped rectangle in raster order
    function automatic void build_expected(input int x0, input int y0, input int w,
                                           input int h, input bit m);
        int ew;
        int eh;
        exp_q.delete();
        ew = (x0 >= SW) ? 0 : ((w < SW - x0) ? w : SW - x0);
        eh = (y0 >= SH) ? 0 : ((h < SH - y0) ? h : SH - y0);
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                exp_q.push_back(pix_t'{x0 + c, y0 + r,
                    (!m) || c == 0 || c == ew - 1 || r == 0 || r == eh - 1});
    endfunction

    task automatic scramble();
        bus.x0        = 8'($urandom_range(0, 255));
        bus.y0        = 7'($urandom_range(0, 127));
        bus.width     = 8'($urandom_range(0, 255));
        bus.height    = 7'($urandom_range(0, 127));
        bus.colour_in = 3'($urandom_range(0, 7));
        bus.mode      = 1'($urandom_range(0, 1));
    endtask

    // Entered one cycle after reset release; leaves at an IDLE negedge
    task automatic run_clear(input string tag);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) begin
                check(tag, cur(), pk(1, 1, 0, c, r, 3'b111));
                @(negedge clock);
            end
        check({tag, "_done"}, ctl(), 21'd1);
        @(negedge clock);
        check({tag, "_idle"}, ctl(), 21'd0);
    endtask

    task automatic run_cmd(input string tag, input int cx0, input int cy0, input int cw,
                           input int ch, input logic [2:0] col, input bit m, input bit spam);
        build_expected(cx0, cy0, cw, ch, m);
        bus.x0        = 8'(cx0);
        bus.y0        = 7'(cy0);
        bus.width     = 8'(cw);
        bus.height    = 7'(ch);
        bus.colour_in = col;
        bus.mode      = m;
        bus.start     = 1'b1;
        @(negedge clock);
        foreach (exp_q[i]) begin
            check(tag, cur(), pk(exp_q[i].plot, 1, 0, exp_q[i].x, exp_q[i].y, col));
            bus.start = spam;
            scramble();
            @(negedge clock);
        end
        check({tag, "_done"}, ctl(), 21'd1);
        bus.start = spam;
        scramble();
        @(negedge clock);
        check({tag, "_idle"}, ctl(), 21'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.x0        = '0;
        bus.y0        = '0;
        bus.width     = '0;
        bus.height    = '0;
        bus.colour_in = '0;
        bus.mode      = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_state", cur(), 21'd0);
        resetn = 1'b1;
        @(negedge clock);
        run_clear("reset_clear");

        run_cmd("solid",      10,  20, 4, 3, 3'b100, 1'b0, 1'b0);
        run_cmd("outline",     0,   0, 4, 4, 3'b010, 1'b1, 1'b0);
        run_cmd("clip_solid", 158, 118, 5, 5, 3'b001, 1'b0, 1'b0);
        run_cmd("clip_outl",  155, 115, 9, 9, 3'b011, 1'b1, 1'b0);
        run_cmd("x_off",      170,  10, 5, 5, 3'b101, 1'b0, 1'b0);
        run_cmd("y_off",       10, 120, 5, 5, 3'b101, 1'b0, 1'b0);
        run_cmd("zero_w",      10,  10, 0, 5, 3'b110, 1'b0, 1'b0);
        run_cmd("line_h",      20,  30, 6, 1, 3'b110, 1'b1, 1'b0);
        run_cmd("line_v",      20,  30, 1, 5, 3'b001, 1'b1, 1'b0);

        // start held through a 12-pixel draw and its done cycle, then a fresh accept
        run_cmd("busy_ignore", 40, 50, 4, 3, 3'b111, 1'b0, 1'b1);
        run_cmd("after_done",  30, 40, 2, 2, 3'b010, 1'b1, 1'b0);

        for (int k = 0; k < 10; k++)
            run_cmd("random", $urandom_range(0, 175), $urandom_range(0, 127),
                    $urandom_range(0, 24), $urandom_range(0, 16),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);

        // Reset on the 5th pixel of a 12-pixel fill
        build_expected(10, 20, 4, 3, 1'b0);
        bus.x0        = 8'd10;
        bus.y0        = 7'd20;
        bus.width     = 8'd4;
        bus.height    = 7'd3;
        bus.colour_in = 3'b100;
        bus.mode      = 1'b0;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("pre_abort", cur(), pk(exp_q[i].plot, 1, 0, exp_q[i].x, exp_q[i].y, 3'b100));
            if (i < 4) @(negedge clock);
        end
        resetn = 1'b0;
        @(negedge clock);
        check("reset_abort", cur(), 21'd0);
        resetn = 1'b1;
        @(negedge clock);
        run_clear("reclear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Parametrised rectangle raster engine that drives the VGA adapter's pixel write port (x, y, colour, plot). It generalises the screen-clear sweep. After reset it optionally clears the whole screen. It then accepts rectangle-draw commands (solid fill or 1-pixel outline) over a start/busy/done handshake from the game controller, one pixel per clock, with clipping to the screen bounds.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
X_W, 8, width of x coordinate and rectangle width fields
Y_W, 7, width of y coordinate and rectangle height fields
COLOUR_W, 3, colour width
CLEAR_ON_RESET, 1, 1 = full-screen fill with CLEAR_COLOUR after reset release
CLEAR_COLOUR, 3'b111, colour used for the reset clear (white)

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  command request, sampled only in IDLE
x0  in  X_W  rectangle left column
y0  in  Y_W  rectangle top row
width  in  X_W  rectangle width in pixels
height  in  Y_W  rectangle height in pixels
colour_in  in  COLOUR_W  draw colour
mode  in  1  0 = solid fill, 1 = outline only
x  out  X_W  pixel column to adapter
y  out  Y_W  pixel row to adapter
colour  out  COLOUR_W  pixel colour to adapter
plot  out  1  write enable to adapter; pixel written when high
busy  out  1  high while clearing or drawing
done  out  1  one-cycle pulse when a clear or command completes

Behaviour:
- Reset (resetn=0 at a clock edge): x=0, y=0, colour=0, plot=0, busy=0, done=0. State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE. Reset mid-draw aborts immediately; no further plots.
- States: CLEAR, IDLE, DRAW, FINISH.
- CLEAR: busy=1. Scans x=0..SCREEN_W-1 (inner), y=0..SCREEN_H-1 (outer), plot=1, colour=CLEAR_COLOUR, one pixel/cycle. Takes exactly SCREEN_W*SCREEN_H cycles, then FINISH. start is ignored.
- IDLE: busy=0, plot=0. If start=1, latch x0, y0, colour_in, mode, and clipped extents:
  - ew = min(width, SCREEN_W-x0); eh = min(height, SCREEN_H-y0).
  - Compute in X_W+1 / Y_W+1 bits. Result is 0 if x0>=SCREEN_W or y0>=SCREEN_H.
  - If ew=0 or eh=0, go to FINISH with no plots. Otherwise go to DRAW.
- DRAW: busy=1. Outputs are registered. The first pixel (x0,y0) is presented the cycle after start is accepted. Raster order: x runs x0..x0+ew-1, then y increments and x wraps to x0. The last pixel is (x0+ew-1, y0+eh-1). Occupancy is exactly ew*eh cycles in both modes.
  - mode=0: plot=1 every pixel.
  - mode=1: plot=1 only when x==x0, x==x0+ew-1, y==y0 or y==y0+eh-1. Interior positions are scanned with plot=0.
  - colour holds the latched value throughout.
- FINISH: plot=0, busy=0, done=1 for exactly one cycle. Next state is IDLE. start asserted in this cycle is ignored. The earliest accept is the following cycle.
- start while busy is ignored; it is not queued. Inputs x0..mode may change freely after the accept cycle.
- Degenerate outlines: ew=1 or eh=1 gives every pixel on the border, so all are plotted.
- Counters never exceed clipped extents. No x/y value outside 0..SCREEN_W-1 / 0..SCREEN_H-1 is ever presented with plot=1.

Test Plan:
- Reset clear: CLEAR_ON_RESET=1, release resetn -> 19200 consecutive plot=1 cycles with colour=3'b111 covering (0,0)..(159,119) in row-major order, then one done pulse; busy falls with done.
- Solid fill: start with x0=10, y0=20, width=4, height=3, colour_in=3'b100, mode=0 -> 12 plots: (10..13,20), (10..13,21), (10..13,22), first at the cycle after accept; then done.
- Outline: x0=0, y0=0, width=4, height=4, mode=1 -> 16 DRAW cycles, 12 plots; (1,1), (2,1), (1,2), (2,2) have plot=0.
- Clipping: x0=158, y0=118, width=5, height=5 -> ew=2, eh=2; plots only (158,118), (159,118), (158,119), (159,119). x0=170 -> no plots, done the cycle after accept.
- Busy/ignore: assert start repeatedly during a 12-pixel draw and in the FINISH cycle -> no second command; a new start the cycle after done is accepted.
- Reset mid-draw: resetn=0 on the 5th pixel of a 12-pixel fill -> next cycle plot=0, busy=0, done=0; with CLEAR_ON_RESET=1 a fresh clear starts at (0,0) after release.
